// File: rtl/pixel_fetch_if.sv
// Pixel request/response port and image-store read port of the pixel fetch engine.
// The master modport is the fetch engine; the slave modport is the requester and image store around it.
interface pixel_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 16
);
    logic [ADDR_W-1:0] addr_pixel;
    logic              request_pixel;
    logic [DATA_W-1:0] pixel;
    logic              pixel_avail;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  addr_pixel, request_pixel, mem_ack, mem_rdata,
        output pixel, pixel_avail, mem_addr, mem_req
    );

    modport slave (
        output addr_pixel, request_pixel, mem_ack, mem_rdata,
        input  pixel, pixel_avail, mem_addr, mem_req
    );
endinterface

// File: rtl/pixel_fetch.sv
// Queues pixel byte-address requests in order and fetches each from a word-wide image
// store over a req/ack port; out-of-range or timed-out fetches return FILL_PIXEL.
module pixel_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] IMG_BASE   = '0,
    parameter int                IMG_WORDS  = 65536,
    parameter int                TIMEOUT    = 255,
    parameter logic [DATA_W-1:0] FILL_PIXEL = '0
) (
    input  logic          clk,
    input  logic          res_n,
    pixel_fetch_if.master bus,
    output logic          busy,
    output logic          err_overflow,
    output logic          err_timeout
);
    localparam int MEM_AW = $clog2(IMG_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    // One bit wider than the address so a store ending at the top of the address space still compares correctly.
    localparam logic [ADDR_W:0]   IMG_LIMIT = {1'b0, IMG_BASE} + (ADDR_W+1)'(longint'(IMG_WORDS) * 4);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fifo_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              pixel_avail_q, pixel_avail_d;
    logic              err_overflow_q, err_overflow_d;
    logic              err_timeout_q, err_timeout_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              head_in_range;
    logic [ADDR_W-1:0] head_addr;
    logic [ADDR_W-1:0] head_offset;
    logic              unused_offset_bits;

    assign head_addr     = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
    assign fifo_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                           (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop           = (state_q == S_IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push          = bus.request_pixel && (!fifo_full || pop);
    assign head_in_range = (head_addr >= IMG_BASE) && ({1'b0, head_addr} < IMG_LIMIT);
    assign head_offset   = head_addr - IMG_BASE;
    assign unused_offset_bits = ^{head_offset[1:0], head_offset[ADDR_W-1:MEM_AW+2]};

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        assign fifo_d[gi] = (push && (wr_ptr_q[PTR_W-1:0] == PTR_W'(gi))) ? bus.addr_pixel : fifo_q[gi];
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        mem_addr_d     = mem_addr_q;
        mem_req_d      = mem_req_q;
        wait_cnt_d     = wait_cnt_q;
        pixel_d        = pixel_q;
        pixel_avail_d  = 1'b0;
        err_overflow_d = err_overflow_q || (bus.request_pixel && fifo_full && !pop);
        err_timeout_d  = err_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
                    if (head_in_range) begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = head_offset[MEM_AW+1:2];
                        wait_cnt_d = '0;
                    end else begin
                        state_d       = S_RESP;
                        pixel_d       = FILL_PIXEL;
                        pixel_avail_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // An ack arriving in the timeout cycle still delivers real data.
                if (bus.mem_ack) begin
                    state_d       = S_RESP;
                    mem_req_d     = 1'b0;
                    pixel_d       = bus.mem_rdata;
                    pixel_avail_d = 1'b1;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
                    state_d       = S_RESP;
                    mem_req_d     = 1'b0;
                    pixel_d       = FILL_PIXEL;
                    pixel_avail_d = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            mem_addr_q     <= '0;
            mem_req_q      <= 1'b0;
            wait_cnt_q     <= '0;
            pixel_q        <= '0;
            pixel_avail_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            mem_addr_q     <= mem_addr_d;
            mem_req_q      <= mem_req_d;
            wait_cnt_q     <= wait_cnt_d;
            pixel_q        <= pixel_d;
            pixel_avail_q  <= pixel_avail_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.pixel       = pixel_q;
    assign bus.pixel_avail = pixel_avail_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_req     = mem_req_q;
    assign busy            = !fifo_empty || (state_q != S_IDLE);
    assign err_overflow    = err_overflow_q;
    assign err_timeout     = err_timeout_q;
endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: directed scenarios plus randomized traffic against a queue-based
// model of in-order responses, an image-store responder with chosen ack latencies, and sticky flags.
module tb_pixel_fetch;
    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam int          FIFO_DEPTH = 4;
    localparam int          IMG_WORDS  = 65536;
    localparam int          MEM_AW     = 16;
    localparam int          TIMEOUT    = 8;
    localparam logic [31:0] IMG_BASE   = 32'h0;
    localparam logic [31:0] FILL       = 32'hF111_0000;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic busy, err_overflow, err_timeout;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pixel_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();

    pixel_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .IMG_BASE(IMG_BASE),
        .IMG_WORDS(IMG_WORDS), .TIMEOUT(TIMEOUT), .FILL_PIXEL(FILL)
    ) dut (
        .clk(clk), .res_n(res_n), .bus(bus),
        .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0]       req_q[$];      // accepted requests awaiting a response
    logic [MEM_AW-1:0] fetch_q[$];    // word addresses the DUT must still fetch, in order
    logic [31:0]       outcome_q[$];  // pixel each started fetch must deliver
    int                lat_q[$];      // forced ack latencies for directed fetches
    bit                exp_ovf = 1'b0;
    bit                exp_to  = 1'b0;
    bit                spur_en = 1'b0;
    int                req_edge = 0;
    int                avail_cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_image(input logic [31:0] a);
        longint base;
        base = longint'(IMG_BASE);
        return (longint'(a) >= base) && (longint'(a) < base + 4 * longint'(IMG_WORDS));
    endfunction

    function automatic logic [MEM_AW-1:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - IMG_BASE) >> 2;
        return off[MEM_AW-1:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [MEM_AW-1:0] w);
        if (w == 16'd4) return 32'hCAFE_0001;
        return {w ^ 16'h3C5A, ~w};
    endfunction

    // Called at a negedge; drives one request strobe and returns at the following negedge.
    task automatic send(input logic [31:0] a, input bit accept);
        bus.addr_pixel    = a;
        bus.request_pixel = 1'b1;
        if (accept) begin
            req_q.push_back(a);
            if (in_image(a)) fetch_q.push_back(word_of(a));
        end else begin
            exp_ovf = 1'b1;
        end
        @(negedge clk);
        req_edge = cyc;
        bus.request_pixel = 1'b0;
        bus.addr_pixel    = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || req_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(n < budget), 64'd1);
        check_eq("err_overflow", 64'(err_overflow), 64'(exp_ovf));
        check_eq("err_timeout", 64'(err_timeout), 64'(exp_to));
    endtask

    // Image-store responder
    bit                in_fetch = 1'b0;
    int                f_idx = 0;
    int                f_lat = 0;
    logic [MEM_AW-1:0] f_word = '0;

    always @(negedge clk) begin
        if (!res_n) begin
            in_fetch      = 1'b0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
        end else if (bus.mem_req) begin
            if (!in_fetch) begin
                in_fetch = 1'b1;
                f_idx    = 0;
                f_lat    = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(0, 9));
                check_eq("req_expected", 64'(fetch_q.size() != 0), 64'd1);
                f_word   = (fetch_q.size() != 0) ? fetch_q.pop_front() : '0;
                if (f_lat < TIMEOUT) begin
                    outcome_q.push_back(mem_word(f_word));
                end else begin
                    outcome_q.push_back(FILL);
                    exp_to = 1'b1;
                end
            end
            check_eq("mem_addr", 64'(bus.mem_addr), 64'(f_word));
            bus.mem_ack   = (f_idx == f_lat);
            bus.mem_rdata = bus.mem_ack ? mem_word(f_word) : $urandom;
            f_idx++;
        end else begin
            if (in_fetch) begin
                in_fetch = 1'b0;
                check_eq("req_len", 64'(f_idx), 64'((f_lat < TIMEOUT) ? f_lat + 1 : TIMEOUT));
            end
            bus.mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
        end
    end

    // Response monitor
    logic [31:0] last_pix = '0;
    bit          prev_avail = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_exp;

    always @(negedge clk) begin
        if (!res_n) begin
            last_pix   = '0;
            prev_avail = 1'b0;
        end else begin
            if (bus.pixel_avail) begin
                check_eq("avail_1cyc", 64'(prev_avail), 64'd0);
                avail_cyc = cyc;
                if (req_q.size() == 0) begin
                    check_eq("extra_resp", 64'(bus.pixel_avail), 64'd0);
                end else begin
                    m_addr = req_q.pop_front();
                    if (!in_image(m_addr)) begin
                        m_exp = FILL;
                    end else begin
                        check_eq("resp_fetched", 64'(outcome_q.size() != 0), 64'd1);
                        m_exp = (outcome_q.size() != 0) ? outcome_q.pop_front() : FILL;
                    end
                    check_eq("pixel", 64'(bus.pixel), 64'(m_exp));
                end
                last_pix = bus.pixel;
            end else begin
                check_eq("pixel_hold", 64'(bus.pixel), 64'(last_pix));
            end
            prev_avail = bus.pixel_avail;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int guard;
        bus.addr_pixel    = '0;
        bus.request_pixel = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pixel", 64'(bus.pixel), 64'd0);
        check_eq("rst_avail", 64'(bus.pixel_avail), 64'd0);
        check_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_flags", 64'({err_overflow, err_timeout}), 64'd0);
        res_n = 1'b1;
        @(negedge clk);

        // In-range fetch, ack in first REQ cycle
        lat_q.push_back(0);
        send(32'h10, 1'b1);
        wait_idle(100);
        check_eq("t1_latency", 64'(avail_cyc - req_edge), 64'd2);
        check_eq("t1_pixel", 64'(bus.pixel), 64'hCAFE_0001);

        // First address past the image
        send(32'(4 * IMG_WORDS), 1'b1);
        wait_idle(100);
        check_eq("t2_latency", 64'(avail_cyc - req_edge), 64'd1);
        check_eq("t2_pixel", 64'(bus.pixel), 64'(FILL));

        // Back-to-back requests with uneven ack latencies
        lat_q.push_back(3); lat_q.push_back(0); lat_q.push_back(5);
        send(32'h0, 1'b1); send(32'h4, 1'b1); send(32'h8, 1'b1);
        wait_idle(200);

        // Timeout
        lat_q.push_back(20);
        send(32'h100, 1'b1);
        wait_idle(100);
        check_eq("t3_pixel", 64'(bus.pixel), 64'(FILL));

        // Overflow: one in flight, four queued, sixth dropped
        lat_q.push_back(6);
        for (int k = 0; k < 4; k++) lat_q.push_back(0);
        for (int k = 0; k < 6; k++) send(32'h200 + 32'(4 * k), k < 5);
        wait_idle(200);

        // Randomized traffic with spurious acks outside REQ
        spur_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            guard = 0;
            while (req_q.size() >= FIFO_DEPTH && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_eq("rand_stall", 64'(guard < 100), 64'd1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case ($urandom_range(0, 3))
                0:       a = 32'(4 * IMG_WORDS) + 32'($urandom_range(0, 4096));
                1:       a = $urandom;
                default: a = (32'($urandom_range(0, IMG_WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
            endcase
            send(a, 1'b1);
        end
        wait_idle(400);
        spur_en = 1'b0;

        // Asynchronous reset in the middle of a fetch
        lat_q.push_back(30);
        send(32'h40, 1'b1);
        repeat (3) @(negedge clk);
        #2 res_n = 1'b0;
        #1;
        check_eq("rst6_mem_req", 64'(bus.mem_req), 64'd0);
        check_eq("rst6_avail", 64'(bus.pixel_avail), 64'd0);
        check_eq("rst6_busy", 64'(busy), 64'd0);
        check_eq("rst6_flags", 64'({err_overflow, err_timeout}), 64'd0);
        @(negedge clk);
        req_q.delete(); fetch_q.delete(); outcome_q.delete(); lat_q.delete();
        exp_ovf = 1'b0;
        exp_to  = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        lat_q.push_back(0);
        send(32'h44, 1'b1);
        wait_idle(100);
        check_eq("t6_latency", 64'(avail_cyc - req_edge), 64'd2);
        check_eq("t6_pixel", 64'(bus.pixel), 64'(mem_word(16'h11)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
